regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 8x8 register file among NREQ writeback sources (ALU, load unit, immediate/move path).
- Round-robin arbitration with a req/ack handshake; drives wr_en, addr_d and data_in from posedge registers, so they are stable before the register file's negedge write.
- Also reports read-after-write hazards on the two read addresses so the sequencer can stall decode.

---
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback sources, plus RAW hazard flags.
// Latency: a request sampled at edge N gives registered ack/wr_en/addr_d/data_in during N..N+1 (regfile commits at negedge).
// Backpressure: hold=1 freezes grants; requesters keep req/addr/data stable until acked.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 8,
    parameter int AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    input  logic                 hold,
    output logic                 wr_en,
    output logic [AW-1:0]        addr_d,
    output logic [DW-1:0]        data_in,
    input  logic [AW-1:0]        chk_addr_a,
    input  logic [AW-1:0]        chk_addr_b,
    output logic                 hazard_a,
    output logic                 hazard_b,
    output logic [(1<<AW)-1:0]   pending
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic            grant_vld;
    logic [PW-1:0]   grant_idx;
    logic [AW-1:0]   grant_addr;
    logic [DW-1:0]   grant_data;
    logic [NREQ-1:0] ack_nxt;
    int              cand;

    // Scan starts just after the last winner, so that winner is considered last.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = ptr;
        grant_addr = '0;
        grant_data = '0;
        ack_nxt    = '0;
        cand       = 0;
        if (!hold) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = (int'(ptr) + k) % NREQ;
                if (!grant_vld && req[cand]) begin
                    grant_vld     = 1'b1;
                    grant_idx     = PW'(cand);
                    grant_addr    = req_addr[cand*AW +: AW];
                    grant_data    = req_data[cand*DW +: DW];
                    ack_nxt[cand] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= PW'(NREQ - 1);
            ack     <= '0;
            wr_en   <= 1'b0;
            addr_d  <= '0;
            data_in <= '0;
        end else if (grant_vld) begin
            ptr     <= grant_idx;
            ack     <= ack_nxt;
            addr_d  <= grant_addr;
            data_in <= grant_data;
            // r0 is hardwired zero: the grant is acked but the write is dropped.
            wr_en   <= (grant_addr != '0);
        end else begin
            ack     <= '0;
            wr_en   <= 1'b0;
        end
    end

    // A request whose ack is high this cycle is already covered by wr_en/addr_d.
    always_comb begin
        pending = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !ack[i])
                pending[req_addr[i*AW +: AW]] = 1'b1;
        end
        if (wr_en)
            pending[addr_d] = 1'b1;
        pending[0] = 1'b0;
    end

    assign hazard_a = pending[chk_addr_a];
    assign hazard_b = pending[chk_addr_b];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, corner sequences, randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 1 << AW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      ack;
    logic                 hold;
    logic                 wr_en;
    logic [AW-1:0]        addr_d;
    logic [DW-1:0]        data_in;
    logic [AW-1:0]        chk_addr_a;
    logic [AW-1:0]        chk_addr_b;
    logic                 hazard_a;
    logic                 hazard_b;
    logic [NREG-1:0]      pending;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .ack        (ack),
        .hold       (hold),
        .wr_en      (wr_en),
        .addr_d     (addr_d),
        .data_in    (data_in),
        .chk_addr_a (chk_addr_a),
        .chk_addr_b (chk_addr_b),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT write port (negedge write, r0 hardwired zero).
    logic [DW-1:0] rf [NREG] = '{default: '0};
    always @(negedge clk) begin
        if (wr_en && addr_d != '0)
            rf[addr_d] <= data_in;
    end

    // Reference model state.
    int              m_ptr = NREQ - 1;
    logic [NREQ-1:0] m_ack = '0;
    logic            m_wr = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_data = '0;
    logic [DW-1:0]   exp_rf [NREG] = '{default: '0};

    always @(negedge clk) begin
        if (m_wr && m_addr != '0)
            exp_rf[m_addr] <= m_data;
    end

    task automatic model_reset();
        m_ptr  = NREQ - 1;
        m_ack  = '0;
        m_wr   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Winner: first requester in the rotation that begins right after the previous winner.
    task automatic model_edge();
        bit found = 1'b0;
        int g = 0;
        m_ack = '0;
        m_wr  = 1'b0;
        if (!hold) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (!found && req[c]) begin
                    found = 1'b1;
                    g = c;
                end
            end
        end
        if (found) begin
            m_ack[g] = 1'b1;
            m_addr   = req_addr[g*AW +: AW];
            m_data   = req_data[g*DW +: DW];
            m_wr     = (m_addr != '0);
            m_ptr    = g;
        end
    endtask

    function automatic logic [NREG-1:0] exp_pending();
        logic [NREG-1:0] p = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int i = 0; i < NREQ; i++)
                if (req[i] && !m_ack[i] && int'(req_addr[i*AW +: AW]) == r) p[r] = 1'b1;
            if (m_wr && int'(m_addr) == r) p[r] = 1'b1;
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [NREG-1:0] ep;
        ep = exp_pending();
        check({tag, ".ack"},     32'(ack),      32'(m_ack));
        check({tag, ".wr_en"},   32'(wr_en),    32'(m_wr));
        check({tag, ".addr_d"},  32'(addr_d),   32'(m_addr));
        check({tag, ".data_in"}, 32'(data_in),  32'(m_data));
        check({tag, ".pending"}, 32'(pending),  32'(ep));
        check({tag, ".hazard_a"}, 32'(hazard_a), 32'(ep[chk_addr_a]));
        check({tag, ".hazard_b"}, 32'(hazard_b), 32'(ep[chk_addr_b]));
        for (int r = 0; r < NREG; r++)
            check($sformatf("%s.rf%0d", tag, r), 32'(rf[r]), 32'(exp_rf[r]));
    endtask

    // Inputs are stable at the edge, so the model samples them right at the edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [NREQ-1:0]    req;
        logic [NREQ*AW-1:0] addr;
        logic [NREQ*DW-1:0] data;
        logic               hold;
        logic [NREQ-1:0]    ack;
        logic               wr;
        logic [AW-1:0]      waddr;
        logic [DW-1:0]      wdata;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = {3'b001, {3'd0, 3'd0, 3'd5}, {8'h00, 8'h00, 8'hA5}, 1'b0, 3'b001, 1'b1, 3'd5, 8'hA5};
        tbl[1]  = {3'b000, {3'd0, 3'd0, 3'd5}, {8'h00, 8'h00, 8'hA5}, 1'b0, 3'b000, 1'b0, 3'd5, 8'hA5};
        tbl[2]  = {3'b100, {3'd3, 3'd0, 3'd0}, {8'h33, 8'h00, 8'h00}, 1'b0, 3'b100, 1'b1, 3'd3, 8'h33};
        tbl[3]  = {3'b111, {3'd3, 3'd2, 3'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b001, 1'b1, 3'd1, 8'h11};
        tbl[4]  = {3'b111, {3'd3, 3'd2, 3'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b010, 1'b1, 3'd2, 8'h22};
        tbl[5]  = {3'b111, {3'd3, 3'd2, 3'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b100, 1'b1, 3'd3, 8'h33};
        tbl[6]  = {3'b111, {3'd3, 3'd2, 3'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b001, 1'b1, 3'd1, 8'h11};
        tbl[7]  = {3'b111, {3'd3, 3'd2, 3'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b010, 1'b1, 3'd2, 8'h22};
        tbl[8]  = {3'b111, {3'd3, 3'd2, 3'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b100, 1'b1, 3'd3, 8'h33};
        tbl[9]  = {3'b010, {3'd0, 3'd0, 3'd0}, {8'h00, 8'hFF, 8'h00}, 1'b0, 3'b010, 1'b0, 3'd0, 8'hFF};
        tbl[10] = {3'b000, {3'd0, 3'd0, 3'd0}, {8'h00, 8'h00, 8'h00}, 1'b0, 3'b000, 1'b0, 3'd0, 8'hFF};
        tbl[11] = {3'b001, {3'd0, 3'd0, 3'd7}, {8'h00, 8'h00, 8'h77}, 1'b1, 3'b000, 1'b0, 3'd0, 8'hFF};
        tbl[12] = {3'b001, {3'd0, 3'd0, 3'd7}, {8'h00, 8'h00, 8'h77}, 1'b0, 3'b001, 1'b1, 3'd7, 8'h77};

        rst = 1'b1;
        req = '0;
        req_addr = '0;
        req_data = '0;
        hold = 1'b0;
        chk_addr_a = '0;
        chk_addr_b = '0;
        model_reset();
        #12;
        check("reset.ack",     32'(ack),     32'h0);
        check("reset.wr_en",   32'(wr_en),   32'h0);
        check("reset.addr_d",  32'(addr_d),  32'h0);
        check("reset.data_in", 32'(data_in), 32'h0);
        check("reset.pending", 32'(pending), 32'h0);
        rst = 1'b0;

        // Directed vectors: first write, round robin, r0 discard, hold.
        for (int v = 0; v < NV; v++) begin
            req = tbl[v].req;
            req_addr = tbl[v].addr;
            req_data = tbl[v].data;
            hold = tbl[v].hold;
            step($sformatf("vec%0d", v));
            check($sformatf("vec%0d.tbl_ack", v),   32'(ack),     32'(tbl[v].ack));
            check($sformatf("vec%0d.tbl_wr", v),    32'(wr_en),   32'(tbl[v].wr));
            check($sformatf("vec%0d.tbl_addr", v),  32'(addr_d),  32'(tbl[v].waddr));
            check($sformatf("vec%0d.tbl_data", v),  32'(data_in), 32'(tbl[v].wdata));
        end
        check("rf5_readback", 32'(rf[5]), 32'hA5);
        check("rf3_readback", 32'(rf[3]), 32'h33);
        check("rf0_zero",     32'(rf[0]), 32'h00);

        // r0 target is never pending and never a hazard.
        req = 3'b010;
        req_addr = {3'd0, 3'd0, 3'd0};
        hold = 1'b1;
        chk_addr_a = 3'd0;
        #1;
        check("r0.pending0", 32'(pending[0]), 32'h0);
        check("r0.hazard_a", 32'(hazard_a),   32'h0);
        req = '0;
        hold = 1'b0;
        step("idle0");

        // Two requesters writing the same register: grant order decides the final value.
        do_reset();
        req = 3'b101;
        req_addr = {3'd4, 3'd0, 3'd4};
        req_data = {8'h22, 8'h00, 8'h11};
        chk_addr_a = 3'd4;
        #1;
        check("sd.haz_before", 32'(hazard_a), 32'h1);
        step("sd1");
        check("sd1.ack",  32'(ack),     32'b001);
        check("sd1.data", 32'(data_in), 32'h11);
        req = 3'b100;
        #1;
        check("sd.haz_mid", 32'(hazard_a), 32'h1);
        step("sd2");
        check("sd2.ack",  32'(ack),     32'b100);
        check("sd2.data", 32'(data_in), 32'h22);
        req = '0;
        #1;
        check("sd.haz_last", 32'(hazard_a), 32'h1);
        step("sd3");
        check("sd.haz_after", 32'(hazard_a), 32'h0);
        check("sd.rf4",       32'(rf[4]),    32'h22);

        // Hold keeps a request pending without granting it.
        hold = 1'b1;
        req = 3'b010;
        req_addr = {3'd0, 3'd7, 3'd0};
        req_data = {8'h00, 8'h77, 8'h00};
        chk_addr_a = 3'd7;
        for (int c = 0; c < 3; c++) begin
            step($sformatf("hold%0d", c));
            check($sformatf("hold%0d.ack", c),  32'(ack),        32'h0);
            check($sformatf("hold%0d.wr", c),   32'(wr_en),      32'h0);
            check($sformatf("hold%0d.pend", c), 32'(pending[7]), 32'h1);
        end
        hold = 1'b0;
        step("unhold");
        check("unhold.ack",  32'(ack),    32'b010);
        check("unhold.wr",   32'(wr_en),  32'h1);
        check("unhold.addr", 32'(addr_d), 32'h7);
        req = '0;
        step("idle1");

        // Reset while a write to r6 is in flight: the negedge write must not happen.
        req = 3'b101;
        req_addr = {3'd6, 3'd0, 3'd1};
        req_data = {8'h66, 8'h00, 8'h5A};
        step("rm0");
        check("rm0.addr", 32'(addr_d), 32'h6);
        check("rm0.wr",   32'(wr_en),  32'h1);
        rst = 1'b1;
        model_reset();
        #1;
        check("rm.wr_drop",  32'(wr_en), 32'h0);
        check("rm.ack_drop", 32'(ack),   32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        check("rm.rf6_kept", 32'(rf[6]), 32'h00);
        step("rm1");
        check("rm1.ack", 32'(ack), 32'b001);
        req[0] = 1'b0;
        step("rm2");
        check("rm2.ack",  32'(ack),     32'b100);
        check("rm2.data", 32'(data_in), 32'h66);
        req = '0;
        step("rm3");
        check("rm.rf6_final", 32'(rf[6]), 32'h66);

        // Randomized traffic: requesters drop on ack and sometimes re-request at once.
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i])
                    req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, NREG - 1));
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            hold = ($urandom_range(0, 4) == 0);
            chk_addr_a = AW'($urandom);
            chk_addr_b = AW'($urandom);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
